// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP stream engine.
package lbp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        EMIT,
        ZERO,
        DONE
    } state_t;

    localparam logic [1:0] MODE_GE     = 2'd0;
    localparam logic [1:0] MODE_GE_THR = 2'd1;
    localparam logic [1:0] MODE_LT     = 2'd2;

    // Window slot feeding each code bit; window is stored column-major.
    localparam int NB_IDX [8] = '{0, 3, 6, 1, 7, 2, 5, 8};
    localparam int CENTER     = 4;

endpackage

// File: rtl/lbp_code.sv
// Combinational 3x3 LBP code from a column-major window.
module lbp_code
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [8:0][DW-1:0] win,
    input  logic [1:0]         mode,
    input  logic [DW-1:0]      thr,
    output logic [7:0]         code
);

    logic [DW:0] ctr;
    logic [DW:0] sum;
    logic [DW:0] nb;

    // Extra bit on the sum: an overflowing c+thr can never be reached.
    always_comb begin
        ctr  = {1'b0, win[CENTER]};
        sum  = ctr + {1'b0, thr};
        nb   = '0;
        code = '0;
        for (int i = 0; i < 8; i++) begin
            nb = {1'b0, win[NB_IDX[i]]};
            case (mode)
                MODE_GE_THR: code[i] = (nb >= sum);
                MODE_LT:     code[i] = (nb < ctr);
                default:     code[i] = (nb >= ctr);
            endcase
        end
    end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: gray memory in, one code per pixel out
// via valid/ready, with optional zero-coded border pixels.
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int DW          = 8,
    parameter int BORDER_ZERO = 0,
    localparam int AW         = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] thr,
    output logic          lbp_valid,
    input  logic          lbp_ready,
    output logic [AW-1:0] lbp_addr,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam logic [AW-1:0] W       = AW'(IMG_W);
    localparam logic [AW-1:0] W_M1    = AW'(IMG_W - 1);
    localparam logic [AW-1:0] W2_M1   = AW'(2 * IMG_W - 1);
    localparam logic [AW-1:0] LAST    = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] COL_END = AW'(IMG_W - 2);
    localparam logic [AW-1:0] ROW_END = AW'(IMG_H - 2);
    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW-1:0] TWO     = AW'(2);

    state_t               state;
    logic [1:0]           mode_q;
    logic [DW-1:0]        thr_q;
    logic [AW-1:0]        row;
    logic [AW-1:0]        col;
    logic [AW-1:0]        row_base;
    logic [AW-1:0]        zend;
    logic                 zlast;
    logic [3:0]           rd_cnt;
    logic [3:0]           cap_idx;
    logic                 pend;
    logic [8:0][DW-1:0]   win;
    logic [8:0][DW-1:0]   cwin;
    logic [7:0]           code;
    logic                 hs;
    logic                 loading;

    assign hs      = lbp_valid & lbp_ready;
    assign loading = (state == FILL) || (state == SHIFT);

    // The last capture always lands in slot 8, so the code is taken
    // from the incoming word and registered in the same edge.
    always_comb begin
        cwin    = win;
        cwin[8] = gray_data;
    end

    lbp_code #(.DW(DW)) u_code (
        .win  (cwin),
        .mode (mode_q),
        .thr  (thr_q),
        .code (code)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            mode_q    <= '0;
            thr_q     <= '0;
            row       <= '0;
            col       <= '0;
            row_base  <= '0;
            zend      <= '0;
            zlast     <= 1'b0;
            rd_cnt    <= '0;
            cap_idx   <= '0;
            pend      <= 1'b0;
            win       <= '0;
            gray_req  <= 1'b0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            finish    <= 1'b0;
        end else begin
            pend <= gray_req;
            if (loading && pend) begin
                win[cap_idx] <= gray_data;
                cap_idx      <= cap_idx + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (gray_ready) begin
                        mode_q   <= mode;
                        thr_q    <= thr;
                        row      <= ONE;
                        col      <= ONE;
                        row_base <= W;
                        if (BORDER_ZERO != 0) begin
                            state     <= ZERO;
                            zend      <= W;
                            zlast     <= 1'b0;
                            lbp_valid <= 1'b1;
                            lbp_addr  <= '0;
                            lbp_data  <= '0;
                        end else begin
                            state     <= FILL;
                            gray_req  <= 1'b1;
                            gray_addr <= '0;
                            rd_cnt    <= 4'd0;
                            cap_idx   <= 4'd0;
                        end
                    end
                end
                FILL, SHIFT: begin
                    if (gray_req) begin
                        if (rd_cnt == 4'd8) begin
                            gray_req <= 1'b0;
                        end else begin
                            rd_cnt <= rd_cnt + 4'd1;
                            // Walk down a column, then hop to the next top.
                            if (rd_cnt == 4'd2 || rd_cnt == 4'd5)
                                gray_addr <= gray_addr - W2_M1;
                            else
                                gray_addr <= gray_addr + W;
                        end
                    end
                    if (pend && cap_idx == 4'd8) begin
                        state     <= EMIT;
                        lbp_valid <= 1'b1;
                        lbp_addr  <= row_base + col;
                        lbp_data  <= code;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        lbp_valid <= 1'b0;
                        if (col < COL_END) begin
                            state     <= SHIFT;
                            col       <= col + ONE;
                            win[5:0]  <= win[8:3];
                            gray_req  <= 1'b1;
                            gray_addr <= row_base - W + col + TWO;
                            rd_cnt    <= 4'd6;
                            cap_idx   <= 4'd6;
                        end else if (row < ROW_END) begin
                            row      <= row + ONE;
                            row_base <= row_base + W;
                            col      <= ONE;
                            if (BORDER_ZERO != 0) begin
                                state     <= ZERO;
                                zend      <= row_base + W;
                                zlast     <= 1'b0;
                                lbp_valid <= 1'b1;
                                lbp_addr  <= row_base + W_M1;
                                lbp_data  <= '0;
                            end else begin
                                state     <= FILL;
                                gray_req  <= 1'b1;
                                gray_addr <= row_base;
                                rd_cnt    <= 4'd0;
                                cap_idx   <= 4'd0;
                            end
                        end else if (BORDER_ZERO != 0) begin
                            state     <= ZERO;
                            zend      <= LAST;
                            zlast     <= 1'b1;
                            lbp_valid <= 1'b1;
                            lbp_addr  <= row_base + W_M1;
                            lbp_data  <= '0;
                        end else begin
                            state    <= DONE;
                            finish   <= 1'b1;
                            lbp_addr <= '0;
                            lbp_data <= '0;
                        end
                    end
                end
                ZERO: begin
                    if (hs) begin
                        if (lbp_addr == zend) begin
                            lbp_valid <= 1'b0;
                            lbp_data  <= '0;
                            if (zlast) begin
                                state    <= DONE;
                                finish   <= 1'b1;
                                lbp_addr <= '0;
                            end else begin
                                state     <= FILL;
                                gray_req  <= 1'b1;
                                gray_addr <= row_base - W;
                                rd_cnt    <= 4'd0;
                                cap_idx   <= 4'd0;
                            end
                        end else begin
                            lbp_addr <= lbp_addr + ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Scoreboard bench: two 4x4 engines (plain and zero-border) and one
// default 128x128 engine, each with its own gray memory and monitor.
module tb_lbp_stream_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void extra(string name, int a);
        checks++;
        errors++;
        $display("FAIL %s: unexpected write at addr %0d", name, a);
    endfunction

    function automatic logic [7:0] pix(int pat, int a);
        case (pat)
            0:       return 8'(a);
            1:       return (a == 5) ? 8'h80 : 8'h85;
            2:       return (a == 5) ? 8'hFE : 8'hFF;
            default: return 8'd7;
        endcase
    endfunction

    // ---------------- instance A: 4x4, no border ----------------
    logic       rst_a, gr_a, greq_a, va, rdy_a, fin_a;
    logic [3:0] gaddr_a, addr_a;
    logic [7:0] gd_a, thr_a, data_a;
    logic [1:0] mode_a;
    int         pat_a = 0;
    int         q_a[$];
    int         nw_a = 0;
    bit         stall_a = 0, held_a = 0, stalled_a = 0;
    int         hold_a = 0;
    logic [3:0] haddr_a;
    logic [7:0] hdata_a;

    lbp_stream_engine #(.IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .reset_n(rst_a), .gray_ready(gr_a),
        .gray_req(greq_a), .gray_addr(gaddr_a), .gray_data(gd_a),
        .mode(mode_a), .thr(thr_a), .lbp_valid(va), .lbp_ready(rdy_a),
        .lbp_addr(addr_a), .lbp_data(data_a), .finish(fin_a)
    );

    always @(posedge clk) gd_a <= pix(pat_a, int'(gaddr_a));

    always @(negedge clk) begin
        if (stalled_a) begin
            cmp("a_stall_valid", int'(va), 1);
            cmp("a_stall_addr", int'(addr_a), int'(haddr_a));
            cmp("a_stall_data", int'(data_a), int'(hdata_a));
        end
        stalled_a = va && !rdy_a;
        if (stalled_a) begin
            haddr_a = addr_a;
            hdata_a = data_a;
            cmp("a_stall_req", int'(greq_a), 0);
        end
        if (va && rdy_a) begin
            nw_a++;
            if (q_a.size() == 0) extra("a_extra", int'(addr_a));
            else begin
                int e;
                e = q_a.pop_front();
                cmp("a_addr", int'(addr_a), e >> 8);
                cmp("a_data", int'(data_a), e & 255);
            end
        end
    end

    initial begin
        rdy_a = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_a) rdy_a = 1'b1;
            else if (hold_a > 0) begin
                rdy_a = 1'b0;
                hold_a--;
            end else if (va && nw_a == 2 && !held_a) begin
                rdy_a  = 1'b0;
                hold_a = 6;
                held_a = 1;
            end else rdy_a = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- instance C: 4x4, zero border ----------------
    logic       rst_c, gr_c, greq_c, vc, rdy_c, fin_c;
    logic [3:0] gaddr_c, addr_c;
    logic [7:0] gd_c, thr_c, data_c;
    logic [1:0] mode_c;
    int         q_c[$];
    int         nw_c = 0;

    lbp_stream_engine #(.IMG_W(4), .IMG_H(4), .BORDER_ZERO(1)) u_c (
        .clk(clk), .reset_n(rst_c), .gray_ready(gr_c),
        .gray_req(greq_c), .gray_addr(gaddr_c), .gray_data(gd_c),
        .mode(mode_c), .thr(thr_c), .lbp_valid(vc), .lbp_ready(rdy_c),
        .lbp_addr(addr_c), .lbp_data(data_c), .finish(fin_c)
    );

    always @(posedge clk) gd_c <= pix(0, int'(gaddr_c));

    always @(negedge clk) begin
        if (vc && rdy_c) begin
            nw_c++;
            if (q_c.size() == 0) extra("c_extra", int'(addr_c));
            else begin
                int e;
                e = q_c.pop_front();
                cmp("c_addr", int'(addr_c), e >> 8);
                cmp("c_data", int'(data_c), e & 255);
            end
        end
    end

    // ---------------- instance B: default 128x128 ----------------
    logic        rst_b, gr_b, greq_b, vb, rdy_b, fin_b;
    logic [13:0] gaddr_b, addr_b;
    logic [7:0]  gd_b, thr_b, data_b;
    logic [1:0]  mode_b;
    int          q_b[$];
    int          nw_b = 0;

    lbp_stream_engine u_b (
        .clk(clk), .reset_n(rst_b), .gray_ready(gr_b),
        .gray_req(greq_b), .gray_addr(gaddr_b), .gray_data(gd_b),
        .mode(mode_b), .thr(thr_b), .lbp_valid(vb), .lbp_ready(rdy_b),
        .lbp_addr(addr_b), .lbp_data(data_b), .finish(fin_b)
    );

    always @(posedge clk) gd_b <= pix(3, int'(gaddr_b));

    always @(negedge clk) begin
        if (vb && rdy_b) begin
            nw_b++;
            if (q_b.size() == 0) extra("b_extra", int'(addr_b));
            else begin
                int e;
                e = q_b.pop_front();
                cmp("b_addr", int'(addr_b), e >> 8);
                cmp("b_data", int'(data_b), e & 255);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_a(input int pat, input int m, input int t,
                         input int e5, input int e6, input int e9,
                         input int e10, input bit st);
        int n;
        int w;
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a   = 1'b1;
        pat_a   = pat;
        mode_a  = 2'(m);
        thr_a   = 8'(t);
        held_a  = 0;
        hold_a  = 0;
        stall_a = st;
        nw_a    = 0;
        q_a.push_back((5 << 8) | e5);
        q_a.push_back((6 << 8) | e6);
        q_a.push_back((9 << 8) | e9);
        q_a.push_back((10 << 8) | e10);
        @(posedge clk);
        #1 gr_a = 1'b1;
        @(posedge clk);
        #1 gr_a = 1'b0;
        mode_a = 2'(m) ^ 2'b10;
        thr_a  = 8'(t + 1);
        n = 0;
        while (!fin_a && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp("a_finish", int'(fin_a), 1);
        cmp("a_pending", q_a.size(), 0);
        cmp("a_writes", nw_a, 4);
        w = nw_a;
        gr_a = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        gr_a = 1'b0;
        cmp("a_done_writes", nw_a, w);
        cmp("a_done_req", int'(greq_a), 0);
        stall_a = 0;
    endtask

    task automatic start_b();
        int n;
        @(posedge clk);
        #1 gr_b = 1'b1;
        @(posedge clk);
        #1 gr_b = 1'b0;
        cmp("b_req_start", int'(greq_b), 1);
        n = 0;
        while (!vb && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp("b_first_latency", n, 10);
    endtask

    initial begin
        int n;
        rst_a = 0; rst_b = 0; rst_c = 0;
        gr_a = 0; gr_b = 0; gr_c = 0;
        mode_a = 0; mode_b = 0; mode_c = 0;
        thr_a = 0; thr_b = 0; thr_c = 0;
        rdy_b = 1; rdy_c = 1;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_req", int'(greq_a), 0);
        cmp("rst_gaddr", int'(gaddr_a), 0);
        cmp("rst_valid", int'(va), 0);
        cmp("rst_addr", int'(addr_a), 0);
        cmp("rst_data", int'(data_a), 0);
        cmp("rst_finish", int'(fin_a), 0);

        run_a(0, 0, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 0);
        run_a(0, 2, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0);
        run_a(0, 3, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 0);
        run_a(1, 1, 5, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        run_a(1, 1, 6, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_a(2, 1, 3, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        run_a(0, 0, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 1);

        rst_c = 1'b1;
        for (int a = 0; a < 16; a++)
            q_c.push_back((a << 8) |
                ((a == 5 || a == 6 || a == 9 || a == 10) ? 8'hF0 : 0));
        @(posedge clk);
        #1 gr_c = 1'b1;
        @(posedge clk);
        #1 gr_c = 1'b0;
        n = 0;
        while (!fin_c && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp("c_finish", int'(fin_c), 1);
        cmp("c_pending", q_c.size(), 0);
        cmp("c_writes", nw_c, 16);

        rst_b = 1'b1;
        for (int r = 1; r < 127; r++)
            for (int c = 1; c < 127; c++)
                q_b.push_back(((r * 128 + c) << 8) | 8'hFF);
        start_b();
        n = 0;
        while (nw_b < 20 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp("b_reached_20", nw_b, 20);
        #3 rst_b = 1'b0;
        #1;
        cmp("b_rst_req", int'(greq_b), 0);
        cmp("b_rst_gaddr", int'(gaddr_b), 0);
        cmp("b_rst_valid", int'(vb), 0);
        cmp("b_rst_addr", int'(addr_b), 0);
        cmp("b_rst_data", int'(data_b), 0);
        cmp("b_rst_finish", int'(fin_b), 0);
        q_b.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        nw_b  = 0;
        for (int r = 1; r < 127; r++)
            for (int c = 1; c < 127; c++)
                q_b.push_back(((r * 128 + c) << 8) | 8'hFF);
        start_b();
        n = 0;
        while (!fin_b && n < 90000) begin
            @(posedge clk);
            #1;
            n++;
        end
        cmp("b_finish", int'(fin_b), 1);
        cmp("b_pending", q_b.size(), 0);
        cmp("b_writes", nw_b, 15876);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
